// File: rtl/fu_branch_rs_if.sv
// Bundles the dispatch, CDB snoop and issue buses of the branch reservation
// station. The station connects through the slave modport; the dispatch/CDB
// driver and branch FU side connect through the master modport.
interface fu_branch_rs_if #(
    parameter int WORD_SIZE_P  = 16,
    parameter int WIDTH_OP     = 4,
    parameter int ROB_ENTRY    = 16,
    parameter int NUM_PHYS_REG = 32,
    parameter int NUM_CDB      = 2
);
    localparam int PT = $clog2(NUM_PHYS_REG);
    localparam int RT = $clog2(ROB_ENTRY);

    // dispatch side
    logic                          disp_v;
    logic                          disp_ready;
    logic [WIDTH_OP-1:0]           disp_opcode;
    logic [WORD_SIZE_P-1:0]        disp_pc;
    logic                          disp_src1_rdy;
    logic                          disp_src2_rdy;
    logic [PT-1:0]                 disp_src1_tag;
    logic [PT-1:0]                 disp_src2_tag;
    logic [WORD_SIZE_P-1:0]        disp_src1_val;
    logic [WORD_SIZE_P-1:0]        disp_src2_val;
    logic [RT-1:0]                 disp_rob_dest;
    logic [PT-1:0]                 disp_reg_dest;

    // common data bus, lane i at [i*width +: width]
    logic [NUM_CDB-1:0]            cdb_v;
    logic [NUM_CDB*PT-1:0]         cdb_dest;
    logic [NUM_CDB*WORD_SIZE_P-1:0] cdb_result;

    // issue side towards the branch FU
    logic                          exe_v;
    logic [WIDTH_OP-1:0]           opcode;
    logic [WORD_SIZE_P-1:0]        pc;
    logic [WORD_SIZE_P-1:0]        operand1;
    logic [WORD_SIZE_P-1:0]        operand2;
    logic [RT-1:0]                 rob_dest;
    logic [PT-1:0]                 reg_dest;

    modport master (
        output disp_v, disp_opcode, disp_pc, disp_src1_rdy, disp_src2_rdy,
               disp_src1_tag, disp_src2_tag, disp_src1_val, disp_src2_val,
               disp_rob_dest, disp_reg_dest, cdb_v, cdb_dest, cdb_result,
        input  disp_ready, exe_v, opcode, pc, operand1, operand2, rob_dest, reg_dest
    );

    modport slave (
        input  disp_v, disp_opcode, disp_pc, disp_src1_rdy, disp_src2_rdy,
               disp_src1_tag, disp_src2_tag, disp_src1_val, disp_src2_val,
               disp_rob_dest, disp_reg_dest, cdb_v, cdb_dest, cdb_result,
        output disp_ready, exe_v, opcode, pc, operand1, operand2, rob_dest, reg_dest
    );
endinterface

// File: rtl/fu_branch_rs.sv
// Branch reservation station: holds dispatched branch ops until both operands
// are valid (snooping the CDB), then issues the oldest ready op, one per cycle.
// Age order is tracked with a per-entry "older than me" bit matrix.
// Optional macro FU_BRANCH_RS_BYPASS_EN: a ready op dispatched into an empty
// station goes straight to the issue register without occupying a slot.
module fu_branch_rs #(
    parameter int RS_ENTRY     = 4,
    parameter int WORD_SIZE_P  = 16,
    parameter int WIDTH_OP     = 4,
    parameter int ROB_ENTRY    = 16,
    parameter int NUM_PHYS_REG = 32,
    parameter int NUM_CDB      = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    fu_branch_rs_if.slave             bus,
    output logic [$clog2(RS_ENTRY):0] count_o
);
    localparam int PT = $clog2(NUM_PHYS_REG);
    localparam int RT = $clog2(ROB_ENTRY);
    localparam int IW = $clog2(RS_ENTRY);
    localparam int CW = IW + 1;
`ifdef FU_BRANCH_RS_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    // returns {hit, value}; lowest matching lane wins
    function automatic logic [WORD_SIZE_P:0] cdb_lookup(
        input logic [PT-1:0]                  tag,
        input logic [NUM_CDB-1:0]             v,
        input logic [NUM_CDB*PT-1:0]          d,
        input logic [NUM_CDB*WORD_SIZE_P-1:0] r
    );
        logic [WORD_SIZE_P:0] res;
        res = '0;
        for (int l = NUM_CDB - 1; l >= 0; l--) begin
            if (v[l] && (d[l*PT +: PT] == tag)) res = {1'b1, r[l*WORD_SIZE_P +: WORD_SIZE_P]};
        end
        return res;
    endfunction

    // entry storage
    logic [RS_ENTRY-1:0]    valid_q;
    logic [WIDTH_OP-1:0]    opcode_q   [RS_ENTRY];
    logic [WORD_SIZE_P-1:0] pc_q       [RS_ENTRY];
    logic [RT-1:0]          rob_q      [RS_ENTRY];
    logic [PT-1:0]          rd_q       [RS_ENTRY];
    logic [RS_ENTRY-1:0]    s1_rdy_q;
    logic [RS_ENTRY-1:0]    s2_rdy_q;
    logic [PT-1:0]          s1_tag_q   [RS_ENTRY];
    logic [PT-1:0]          s2_tag_q   [RS_ENTRY];
    logic [WORD_SIZE_P-1:0] s1_val_q   [RS_ENTRY];
    logic [WORD_SIZE_P-1:0] s2_val_q   [RS_ENTRY];
    logic [RS_ENTRY-1:0]    older_q    [RS_ENTRY];   // bit j: entry j is older than entry i
    logic [CW-1:0]          count_q, count_d;

    logic [RS_ENTRY-1:0]    ready_vec, sel_vec, s1_hit, s2_hit;
    logic [WORD_SIZE_P-1:0] s1_wval [RS_ENTRY];
    logic [WORD_SIZE_P-1:0] s2_wval [RS_ENTRY];
    logic                   issue_en;
    logic [IW-1:0]          sel_idx, alloc_idx;

    // per-entry wakeup lookup and oldest-ready selection
    for (genvar gi = 0; gi < RS_ENTRY; gi++) begin : g_entry
        assign {s1_hit[gi], s1_wval[gi]} = cdb_lookup(s1_tag_q[gi], bus.cdb_v, bus.cdb_dest, bus.cdb_result);
        assign {s2_hit[gi], s2_wval[gi]} = cdb_lookup(s2_tag_q[gi], bus.cdb_v, bus.cdb_dest, bus.cdb_result);
        assign ready_vec[gi] = valid_q[gi] & s1_rdy_q[gi] & s2_rdy_q[gi];
        assign sel_vec[gi]   = ready_vec[gi] & ~|(ready_vec & older_q[gi]);
    end

    // dispatched op, including a CDB capture in the dispatch cycle
    logic                   d1_hit, d2_hit, d1_rdy, d2_rdy;
    logic [WORD_SIZE_P-1:0] d1_wval, d2_wval, d1_val, d2_val;
    logic                   disp_acc, bypass_go, alloc_en;

    assign {d1_hit, d1_wval} = cdb_lookup(bus.disp_src1_tag, bus.cdb_v, bus.cdb_dest, bus.cdb_result);
    assign {d2_hit, d2_wval} = cdb_lookup(bus.disp_src2_tag, bus.cdb_v, bus.cdb_dest, bus.cdb_result);
    assign d1_rdy = bus.disp_src1_rdy | d1_hit;
    assign d2_rdy = bus.disp_src2_rdy | d2_hit;
    assign d1_val = bus.disp_src1_rdy ? bus.disp_src1_val : d1_wval;
    assign d2_val = bus.disp_src2_rdy ? bus.disp_src2_val : d2_wval;

    // readiness comes from registered occupancy only
    assign bus.disp_ready = (count_q < CW'(RS_ENTRY));
    assign disp_acc  = bus.disp_v & bus.disp_ready & ~flush_i;
    assign bypass_go = BYPASS_EN & disp_acc & (count_q == '0) & d1_rdy & d2_rdy;
    assign alloc_en  = disp_acc & ~bypass_go;
    assign count_o   = count_q;

    // encode the selected entry and the lowest free slot
    always_comb begin
        issue_en  = 1'b0;
        sel_idx   = '0;
        alloc_idx = '0;
        for (int i = RS_ENTRY - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                issue_en = 1'b1;
                sel_idx  = IW'(i);
            end
            if (!valid_q[i]) alloc_idx = IW'(i);
        end
        count_d = count_q + CW'(alloc_en) - CW'(issue_en);
    end

    // entry state: wakeup, free on issue, allocate on dispatch
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            valid_q <= '0;
            for (int i = 0; i < RS_ENTRY; i++) older_q[i] <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRY; i++) begin
                if (valid_q[i] && !s1_rdy_q[i] && s1_hit[i]) begin
                    s1_rdy_q[i] <= 1'b1;
                    s1_val_q[i] <= s1_wval[i];
                end
                if (valid_q[i] && !s2_rdy_q[i] && s2_hit[i]) begin
                    s2_rdy_q[i] <= 1'b1;
                    s2_val_q[i] <= s2_wval[i];
                end
            end
            if (issue_en) valid_q[sel_idx] <= 1'b0;
            if (alloc_en) begin
                valid_q[alloc_idx]  <= 1'b1;
                opcode_q[alloc_idx] <= bus.disp_opcode;
                pc_q[alloc_idx]     <= bus.disp_pc;
                rob_q[alloc_idx]    <= bus.disp_rob_dest;
                rd_q[alloc_idx]     <= bus.disp_reg_dest;
                s1_rdy_q[alloc_idx] <= d1_rdy;
                s2_rdy_q[alloc_idx] <= d2_rdy;
                s1_tag_q[alloc_idx] <= bus.disp_src1_tag;
                s2_tag_q[alloc_idx] <= bus.disp_src2_tag;
                s1_val_q[alloc_idx] <= d1_val;
                s2_val_q[alloc_idx] <= d2_val;
                older_q[alloc_idx]  <= valid_q;
                for (int j = 0; j < RS_ENTRY; j++) begin
                    if (IW'(j) != alloc_idx) older_q[j][alloc_idx] <= 1'b0;
                end
            end
        end
    end

    // occupancy counter
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) count_q <= '0;
        else                    count_q <= count_d;
    end

    // issue register towards the branch FU; fields hold when idle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bus.exe_v    <= 1'b0;
            bus.opcode   <= '0;
            bus.pc       <= '0;
            bus.operand1 <= '0;
            bus.operand2 <= '0;
            bus.rob_dest <= '0;
            bus.reg_dest <= '0;
        end else if (flush_i) begin
            bus.exe_v <= 1'b0;
        end else if (issue_en) begin
            bus.exe_v    <= 1'b1;
            bus.opcode   <= opcode_q[sel_idx];
            bus.pc       <= pc_q[sel_idx];
            bus.operand1 <= s1_val_q[sel_idx];
            bus.operand2 <= s2_val_q[sel_idx];
            bus.rob_dest <= rob_q[sel_idx];
            bus.reg_dest <= rd_q[sel_idx];
        end else if (bypass_go) begin
            bus.exe_v    <= 1'b1;
            bus.opcode   <= bus.disp_opcode;
            bus.pc       <= bus.disp_pc;
            bus.operand1 <= d1_val;
            bus.operand2 <= d2_val;
            bus.rob_dest <= bus.disp_rob_dest;
            bus.reg_dest <= bus.disp_reg_dest;
        end else begin
            bus.exe_v <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fu_branch_rs.sv
// Testbench for fu_branch_rs: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the station.
module tb_fu_branch_rs;
    localparam int RS = 4;
    localparam logic [3:0] OP_BCC = 4'd1;
    localparam logic [3:0] OP_BL  = 4'd2;
    localparam logic [3:0] OP_JR  = 4'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    fu_branch_rs_if bus ();

    fu_branch_rs dut (
        .clk_i   (clk),
        .reset_i (rst),
        .flush_i (flush),
        .bus     (bus),
        .count_o (count)
    );

    // model: ops held in dispatch order
    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] pc;
        logic [3:0]  rob;
        logic [4:0]  rd;
        logic        r1;
        logic [4:0]  t1;
        logic [15:0] v1;
        logic        r2;
        logic [4:0]  t2;
        logic [15:0] v2;
    } ent_t;

    ent_t        mq[$];
    logic        e_v;
    logic [3:0]  e_op;
    logic [15:0] e_pc, e_o1, e_o2;
    logic [3:0]  e_rob;
    logic [4:0]  e_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // an operand not yet valid picks up the first broadcasting lane with its tag
    function automatic void snoop(input logic [4:0] tag, inout logic r, inout logic [15:0] v);
        if (r) return;
        for (int l = 0; l < 2; l++) begin
            if (bus.cdb_v[l] && bus.cdb_dest[l*5 +: 5] == tag) begin
                r = 1'b1;
                v = bus.cdb_result[l*16 +: 16];
                return;
            end
        end
    endfunction

    function automatic void model_step();
        ent_t nd, e;
        int   idx;
        bit   acc, byp;
        logic r;
        logic [15:0] v;
        if (rst) begin
            mq.delete();
            e_v = 0; e_op = 0; e_pc = 0; e_o1 = 0; e_o2 = 0; e_rob = 0; e_rd = 0;
            return;
        end
        if (flush) begin
            mq.delete();
            e_v = 0;
            return;
        end
        acc = bus.disp_v && (mq.size() < RS);
        nd.op = bus.disp_opcode; nd.pc = bus.disp_pc;
        nd.rob = bus.disp_rob_dest; nd.rd = bus.disp_reg_dest;
        nd.t1 = bus.disp_src1_tag; nd.t2 = bus.disp_src2_tag;
        r = bus.disp_src1_rdy; v = bus.disp_src1_val; snoop(nd.t1, r, v); nd.r1 = r; nd.v1 = v;
        r = bus.disp_src2_rdy; v = bus.disp_src2_val; snoop(nd.t2, r, v); nd.r2 = r; nd.v2 = v;
`ifdef FU_BRANCH_RS_BYPASS_EN
        byp = acc && (mq.size() == 0) && nd.r1 && nd.r2;
`else
        byp = 1'b0;
`endif
        idx = -1;
        foreach (mq[i]) begin
            if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
        end
        e_v = 0;
        if (idx >= 0) begin
            e = mq[idx];
            e_v = 1; e_op = e.op; e_pc = e.pc; e_o1 = e.v1; e_o2 = e.v2; e_rob = e.rob; e_rd = e.rd;
        end else if (byp) begin
            e_v = 1; e_op = nd.op; e_pc = nd.pc; e_o1 = nd.v1; e_o2 = nd.v2; e_rob = nd.rob; e_rd = nd.rd;
        end
        foreach (mq[i]) begin
            e = mq[i];
            r = e.r1; v = e.v1; snoop(e.t1, r, v); e.r1 = r; e.v1 = v;
            r = e.r2; v = e.v2; snoop(e.t2, r, v); e.r2 = r; e.v2 = v;
            mq[i] = e;
        end
        if (idx >= 0) mq.delete(idx);
        if (acc && !byp) mq.push_back(nd);
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("exe_v",      bus.exe_v,      e_v);
        check("opcode",     bus.opcode,     e_op);
        check("pc",         bus.pc,         e_pc);
        check("operand1",   bus.operand1,   e_o1);
        check("operand2",   bus.operand2,   e_o2);
        check("rob_dest",   bus.rob_dest,   e_rob);
        check("reg_dest",   bus.reg_dest,   e_rd);
        check("count",      count,          mq.size());
        check("disp_ready", bus.disp_ready, mq.size() < RS);
    endtask

    task automatic idle();
        bus.disp_v = 0; bus.disp_opcode = 0; bus.disp_pc = 0;
        bus.disp_src1_rdy = 0; bus.disp_src2_rdy = 0;
        bus.disp_src1_tag = 0; bus.disp_src2_tag = 0;
        bus.disp_src1_val = 0; bus.disp_src2_val = 0;
        bus.disp_rob_dest = 0; bus.disp_reg_dest = 0;
        bus.cdb_v = 0; bus.cdb_dest = 0; bus.cdb_result = 0;
        flush = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [15:0] pc,
                        input logic r1, input logic [4:0] t1, input logic [15:0] v1,
                        input logic r2, input logic [4:0] t2, input logic [15:0] v2,
                        input logic [3:0] rob, input logic [4:0] rd);
        bus.disp_v = 1; bus.disp_opcode = op; bus.disp_pc = pc;
        bus.disp_src1_rdy = r1; bus.disp_src1_tag = t1; bus.disp_src1_val = v1;
        bus.disp_src2_rdy = r2; bus.disp_src2_tag = t2; bus.disp_src2_val = v2;
        bus.disp_rob_dest = rob; bus.disp_reg_dest = rd;
    endtask

    task automatic cdb(input int lane, input logic [4:0] tag, input logic [15:0] val);
        bus.cdb_v[lane] = 1'b1;
        bus.cdb_dest[lane*5 +: 5] = tag;
        bus.cdb_result[lane*16 +: 16] = val;
    endtask

    initial begin
        logic [4:0]  tg0;
        logic [15:0] vl0;
        idle();
        rst = 1;
        repeat (3) cycle();
        check("rst_exe_v", bus.exe_v, 0);
        check("rst_count", count, 0);
        rst = 0;
        cycle();
        check("rst_ready", bus.disp_ready, 1);

        // ready BL: 2-edge latency (1 with bypass)
        disp(OP_BL, 16'h0010, 1, 0, 16'h0001, 1, 0, 16'h0002, 4'd3, 5'd5);
        cycle();
        idle();
`ifdef FU_BRANCH_RS_BYPASS_EN
        check("t1_byp_exe", bus.exe_v, 1);
        check("t1_byp_pc",  bus.pc, 16'h0010);
`else
        check("t1_e0_exe",  bus.exe_v, 0);
`endif
        cycle();
`ifndef FU_BRANCH_RS_BYPASS_EN
        check("t1_exe", bus.exe_v, 1);
        check("t1_pc",  bus.pc, 16'h0010);
        check("t1_op2", bus.operand2, 16'h0002);
        check("t1_rob", bus.rob_dest, 3);
        check("t1_rd",  bus.reg_dest, 5);
`endif
        cycle();
        check("t1_cnt", count, 0);

        // BCC waiting on tag 7, woken by lane 1 after 3 idle cycles
        disp(OP_BCC, 16'h0020, 1, 0, 16'hAAAA, 0, 5'd7, 16'h0000, 4'd1, 5'd6);
        cycle();
        idle();
        repeat (3) begin
            cycle();
            check("t2_wait", bus.exe_v, 0);
        end
        cdb(1, 5'd7, 16'h00F0);
        cycle();
        idle();
        check("t2_ew", bus.exe_v, 0);
        cycle();
        check("t2_exe", bus.exe_v, 1);
        check("t2_op2", bus.operand2, 16'h00F0);

        // CDB match in the dispatch cycle is captured
        disp(OP_JR, 16'h0030, 0, 5'd9, 16'h0000, 1, 0, 16'h0003, 4'd2, 5'd7);
        cdb(0, 5'd9, 16'h1234);
        cycle();
        idle();
`ifndef FU_BRANCH_RS_BYPASS_EN
        cycle();
`endif
        check("t3_exe", bus.exe_v, 1);
        check("t3_op1", bus.operand1, 16'h1234);
        cycle();

        // fill all entries waiting on tag 4
        for (int k = 0; k < 4; k++) begin
            disp(OP_BCC, 16'h0100 + 16'(k), 0, 5'd4, 16'h0000, 1, 0, 16'(k), 4'(k), 5'(k));
            cycle();
        end
        idle();
        check("t4_ready", bus.disp_ready, 0);
        check("t4_count", count, 4);
        disp(OP_BL, 16'h0999, 1, 0, 16'h0000, 1, 0, 16'h0000, 4'd9, 5'd9);
        cycle();
        idle();
        cdb(0, 5'd4, 16'h4444);
        cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t4_exe", bus.exe_v, 1);
            check("t4_rob", bus.rob_dest, k);
            if (k == 0) check("t4_reopen", bus.disp_ready, 1);
        end
        cycle();

        // older waiting A vs younger ready B
        disp(OP_BCC, 16'h0200, 0, 5'd11, 16'h0000, 1, 0, 16'h0001, 4'd5, 5'd1);
        cycle();
        idle();
        cycle();
        disp(OP_BL, 16'h0210, 1, 0, 16'h0002, 1, 0, 16'h0003, 4'd6, 5'd2);
        cdb(0, 5'd11, 16'h0B0B);
        cycle();
        idle();
        cycle();
        check("t5_first",  bus.rob_dest, 5);
        cycle();
        check("t5_second", bus.rob_dest, 6);
        cycle();

        // flush with a dispatch in the same cycle
        for (int k = 0; k < 3; k++) begin
            disp(OP_BCC, 16'h0300 + 16'(k), 0, 5'd13, 16'h0000, 1, 0, 16'h0000, 4'(7 + k), 5'd3);
            cycle();
        end
        disp(OP_BL, 16'h0310, 1, 0, 16'h0001, 1, 0, 16'h0001, 4'd10, 5'd4);
        flush = 1;
        cycle();
        idle();
        check("t6_count", count, 0);
        check("t6_exe", bus.exe_v, 0);
        cdb(0, 5'd13, 16'h1313);
        cycle();
        idle();
        repeat (4) begin
            cycle();
            check("t6_noissue", bus.exe_v, 0);
        end

        // random traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(0, 2) != 0)
                disp(4'($urandom_range(1, 3)), 16'($urandom),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 16'($urandom),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 16'($urandom),
                     4'(c), 5'($urandom));
            tg0 = 5'($urandom_range(0, 7));
            vl0 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) cdb(0, tg0, vl0);
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0) cdb(1, tg0, vl0);
                else cdb(1, 5'($urandom_range(8, 15)) - 5'd8, 16'($urandom));
            end
            if (bus.cdb_v == 2'b11 && bus.cdb_dest[9:5] == bus.cdb_dest[4:0])
                bus.cdb_result[31:16] = bus.cdb_result[15:0];
            flush = ($urandom_range(0, 31) == 0);
            cycle();
        end

        // drain: broadcast every tag so all held ops complete
        for (int c = 0; c < 20; c++) begin
            idle();
            cdb(0, 5'((2 * c) % 8), 16'($urandom));
            cdb(1, 5'((2 * c + 1) % 8), 16'($urandom));
            cycle();
        end
        idle();
        repeat (3) cycle();
        check("drain_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fu_branch_rs.md
Name: fu_branch_rs

Overview:
- Branch reservation station: buffers dispatched branch ops (BCC, BL, register-indirect) until both source operands are available, then issues one op per cycle to the branch functional unit.
- Sits between dispatch/rename and the branch FU.
- Snoops the CDB to wake up waiting operands.
- Flushed on branch mispredict.

Parameters:
RS_ENTRY, 4, number of station entries (power of two, >=2)
WORD_SIZE_P, 16, data/PC width
WIDTH_OP, 4, opcode width
ROB_ENTRY, 16, ROB depth; ROB tag is $clog2(ROB_ENTRY) bits
NUM_PHYS_REG, 32, physical registers; tag is $clog2(NUM_PHYS_REG) bits (PT)
NUM_CDB, 2, CDB broadcast lanes snooped

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
flush_i  in  1  mispredict flush; kill all held and issuing ops
disp_v_i  in  1  dispatch valid
disp_ready_o  out  1  station can accept a dispatch this cycle
disp_opcode_i  in  WIDTH_OP  branch opcode
disp_pc_i  in  WORD_SIZE_P  PC of branch
disp_src1_rdy_i / disp_src2_rdy_i  in  1 each  operand value already valid
disp_src1_tag_i / disp_src2_tag_i  in  PT each  producer phys reg when not ready
disp_src1_val_i / disp_src2_val_i  in  WORD_SIZE_P each  operand value when ready
disp_rob_dest_i  in  $clog2(ROB_ENTRY)  ROB tag
disp_reg_dest_i  in  PT  dest phys reg (BL link)
cdb_v_i  in  NUM_CDB  per-lane broadcast valid
cdb_dest_i  in  NUM_CDB*PT  per-lane tag, lane i at [i*PT +: PT]
cdb_result_i  in  NUM_CDB*WORD_SIZE_P  per-lane value
exe_v_o  out  1  issue valid to branch FU
opcode_o  out  WIDTH_OP  issued opcode
pc_o  out  WORD_SIZE_P  issued PC
operand1_o / operand2_o  out  WORD_SIZE_P each  issued src1/src2 values
rob_dest_o  out  $clog2(ROB_ENTRY)  issued ROB tag
reg_dest_o  out  PT  issued dest reg
count_o  out  $clog2(RS_ENTRY)+1  occupied entries (debug/perf)

Behaviour:
- Reset (synchronous, active-high): all entries invalid; exe_v_o=0 and all issue outputs 0; count_o=0; disp_ready_o=1 the cycle after reset deasserts.
- Each entry holds: valid, opcode, pc, rob_dest, reg_dest, and per source {rdy, tag, val}.
- disp_ready_o = (count_o < RS_ENTRY), from registered state only; a same-cycle issue does not free a slot for dispatch.
- Dispatch is accepted when disp_v_i && disp_ready_o && !flush_i. The entry is written at the next edge into the lowest-index free slot.
- Wakeup: on every edge, each valid not-ready source whose tag equals a valid CDB lane's tag takes that lane's value and sets rdy.
  - This also applies to the op being dispatched this cycle: a CDB match in the dispatch cycle is captured, never lost.
  - If multiple lanes match the same tag, the lowest lane wins (producers are unique; the bench never drives conflicting values).
- Select: each cycle, among entries with both sources rdy (per current registered state), pick the oldest by dispatch order. The entry is freed at the edge.
- Issue register: selected fields are latched into the output registers at the same edge; exe_v_o=1 for exactly one cycle per issued op.
  - Latency: op dispatched ready at edge E0 gives exe_v_o high after E1 (1-cycle station residency).
  - Op woken by CDB at edge Ew issues after Ew+1 at the earliest.
- Issue never stalls: the branch FU accepts every cycle. Throughput is 1 op/cycle.
- count_o next = count + accepted_dispatch - issued.
- Full: count_o==RS_ENTRY blocks dispatch; an issue in that cycle re-opens dispatch the next cycle.
- Empty: exe_v_o=0 and output fields hold their last values.
- Flush: at the edge where flush_i=1, all entries become invalid, exe_v_o<=0, count_o<=0, and same-cycle dispatch is dropped. Flush has priority over dispatch, wakeup and issue.
- Reset has priority over flush.

Optional Feature:
- Macro: FU_BRANCH_RS_BYPASS_EN.
- With macro: when the station is empty and the dispatched op has both sources ready (after same-cycle CDB capture), the op goes directly into the issue register at E0 and exe_v_o is high after E0. It never occupies a slot and count_o is unchanged. The bypass is suppressed by flush_i.
- Without macro: the minimum dispatch-to-exe_v_o latency is always 2 edges.

Test Plan:
- Reset, then dispatch BL pc=0x0010, src1/src2 ready=0x0001/0x0002, rob 3, reg 5 → exe_v_o one cycle after E1 with pc_o=0x0010, operand2_o=0x0002, rob_dest_o=3, reg_dest_o=5, count_o back to 0. With bypass enabled, exe_v_o is high one cycle earlier.
- Dispatch BCC with src2 tag=7 not ready; after 3 idle cycles, drive CDB lane1 dest=7 result=0x00F0 → operand2_o=0x00F0 issued 2 edges after the broadcast; no issue before it.
- CDB lane0 dest=9 result=0x1234 in the same cycle as dispatch of an op waiting on tag 9 → op issues with operand1_o=0x1234; no deadlock.
- Fill 4 entries all waiting on tag 4 → disp_ready_o=0, count_o=4. Broadcast tag 4 → four issues on consecutive cycles in dispatch order (check rob_dest_o sequence 0,1,2,3). disp_ready_o=1 the cycle after the first issue.
- Entries A (older, waiting) and B (younger, ready); wake A → the cycle after wakeup both are ready and A issues first, then B.
- 3 entries held, assert flush_i together with disp_v_i → count_o=0, exe_v_o=0 next cycle, no later issue of any of the 4 ops.
